game_round_ctrl: RTL and testbench

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

---
 rtl/game_round_ctrl_if.sv | 38 +++
 rtl/game_round_ctrl.sv | 144 ++++++++++++++
 tb/tb_game_round_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/game_round_ctrl_if.sv
// Signal bundle between the round controller and the game top level.
// master drives frame strobe, keycode and object positions; slave (the controller) drives round status.
interface game_round_ctrl_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] tank0_X;
    logic [9:0] tank0_Y;
    logic [9:0] tank1_X;
    logic [9:0] tank1_Y;
    logic [9:0] bullet0_X;
    logic [9:0] bullet0_Y;
    logic [9:0] bullet1_X;
    logic [9:0] bullet1_Y;
    logic [1:0] hit0;
    logic [1:0] hit1;
    logic       round_reset;
    logic       freeze;
    logic [3:0] score0;
    logic [3:0] score1;
    logic [1:0] winner;
    logic [1:0] game_state;

    modport master (
        output frame_clk, keycode,
        output tank0_X, tank0_Y, tank1_X, tank1_Y,
        output bullet0_X, bullet0_Y, bullet1_X, bullet1_Y,
        output hit0, hit1,
        input  round_reset, freeze, score0, score1, winner, game_state
    );

    modport slave (
        input  frame_clk, keycode,
        input  tank0_X, tank0_Y, tank1_X, tank1_Y,
        input  bullet0_X, bullet0_Y, bullet1_X, bullet1_Y,
        input  hit0, hit1,
        output round_reset, freeze, score0, score1, winner, game_state
    );
endinterface

// File: rtl/game_round_ctrl.sv
// Tank game round sequencer: start/restart, hit scoring, post-hit pause, game over.
// Optional GAME_TIE_ROUND_EN: simultaneous hits score nothing and the round is replayed.
//
// state   | meaning
// IDLE    | waiting for start key, play frozen
// PLAY    | tanks live, hits evaluated each frame
// PAUSE   | freeze after a hit, down-counting frames
// OVER    | a player reached WIN_SCORE, winner shown
module game_round_ctrl #(
    parameter logic [3:0] WIN_SCORE    = 4'd5,
    parameter logic [7:0] PAUSE_FRAMES = 8'd60,
    parameter logic [7:0] START_KEY    = 8'h13,
    parameter logic [9:0] TANK_SIZE    = 10'd32,
    parameter logic [9:0] BULLET_SIZE  = 10'd8
) (
    input logic         Clk,
    input logic         Reset,
    game_round_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t     state, state_d;
    logic [3:0] score0, score0_d;
    logic [3:0] score1, score1_d;
    logic [1:0] winner, winner_d;
    logic [7:0] pause_cnt, pause_cnt_d;
    logic       round_reset, round_reset_d;
    logic       fc_q1, fc_q2, fe;
    logic       hit_0on1, hit_1on0;
    logic       start_key;

    // Extents are widened to 11 bits so edge sums near the screen limit cannot wrap.
    function automatic logic box_hit(input logic [9:0] bx, input logic [9:0] by,
                                     input logic [9:0] tx, input logic [9:0] ty);
        logic x_ok, y_ok;
        x_ok = ({1'b0, bx} <= ({1'b0, tx} + {1'b0, TANK_SIZE})) &&
               (({1'b0, bx} + {1'b0, BULLET_SIZE}) >= {1'b0, tx});
        y_ok = ({1'b0, by} <= ({1'b0, ty} + {1'b0, TANK_SIZE})) &&
               (({1'b0, by} + {1'b0, BULLET_SIZE}) >= {1'b0, ty});
        return x_ok && y_ok;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_SCORE) ? WIN_SCORE : s + 4'd1;
    endfunction

    assign hit_0on1  = (bus.hit0 == 2'b01) &&
                       box_hit(bus.bullet0_X, bus.bullet0_Y, bus.tank1_X, bus.tank1_Y);
    assign hit_1on0  = (bus.hit1 == 2'b01) &&
                       box_hit(bus.bullet1_X, bus.bullet1_Y, bus.tank0_X, bus.tank0_Y);
    assign start_key = (bus.keycode == START_KEY);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_q1       <= 1'b0;
            fc_q2       <= 1'b0;
            fe          <= 1'b0;
            state       <= S_IDLE;
            score0      <= 4'd0;
            score1      <= 4'd0;
            winner      <= 2'b00;
            pause_cnt   <= 8'd0;
            round_reset <= 1'b0;
        end else begin
            fc_q1       <= bus.frame_clk;
            fc_q2       <= fc_q1;
            fe          <= fc_q1 & ~fc_q2;
            state       <= state_d;
            score0      <= score0_d;
            score1      <= score1_d;
            winner      <= winner_d;
            pause_cnt   <= pause_cnt_d;
            round_reset <= round_reset_d;
        end
    end

    always_comb begin
        state_d       = state;
        score0_d      = score0;
        score1_d      = score1;
        winner_d      = winner;
        pause_cnt_d   = pause_cnt;
        round_reset_d = 1'b0;
        if (fe) begin
            case (state)
                S_IDLE: begin
                    if (start_key) begin
                        score0_d      = 4'd0;
                        score1_d      = 4'd0;
                        winner_d      = 2'b00;
                        round_reset_d = 1'b1;
                        state_d       = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (hit_0on1 || hit_1on0) begin
`ifdef GAME_TIE_ROUND_EN
                        if (!(hit_0on1 && hit_1on0)) begin
                            if (hit_0on1) score0_d = sat_inc(score0);
                            if (hit_1on0) score1_d = sat_inc(score1);
                        end
`else
                        if (hit_0on1) score0_d = sat_inc(score0);
                        if (hit_1on0) score1_d = sat_inc(score1);
`endif
                        pause_cnt_d = PAUSE_FRAMES;
                        state_d     = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (pause_cnt == 8'd0) begin
                        if (score0 == WIN_SCORE || score1 == WIN_SCORE) begin
                            winner_d = {score1 == WIN_SCORE, score0 == WIN_SCORE};
                            state_d  = S_OVER;
                        end else begin
                            round_reset_d = 1'b1;
                            state_d       = S_PLAY;
                        end
                    end else begin
                        pause_cnt_d = pause_cnt - 8'd1;
                    end
                end
                S_OVER: begin
                    if (start_key) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.round_reset = round_reset;
    assign bus.freeze      = (state != S_PLAY);
    assign bus.score0      = score0;
    assign bus.score1      = score1;
    assign bus.winner      = winner;
    assign bus.game_state  = state;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed self-checking bench for game_round_ctrl with default parameters.
// Honours GAME_TIE_ROUND_EN for the simultaneous-hit expectations.
module tb_game_round_ctrl;

    logic Clk;
    logic Reset;
    int   n_chk;
    int   n_fail;
    int   rr_cnt;
    int   rr0;

    game_round_ctrl_if bus ();

    game_round_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame strobe; round_reset is sampled on every falling edge so a pulse is never missed.
    task automatic do_frame();
        @(negedge Clk);
        bus.frame_clk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (i == 1) bus.frame_clk = 1'b0;
            if (bus.round_reset) rr_cnt++;
        end
    endtask

    // Hit frame followed by the full pause (PAUSE_FRAMES decrements plus the exit frame).
    task automatic round(input logic h0, input logic h1, input string tag);
        bus.hit0 = h0 ? 2'b01 : 2'b00;
        bus.hit1 = h1 ? 2'b01 : 2'b00;
        do_frame();
        bus.hit0 = 2'b00;
        bus.hit1 = 2'b00;
        chk({tag, "_pause"}, bus.game_state, 2'b10);
        repeat (61) do_frame();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rr_cnt = 0;
        Reset = 1'b1;
        bus.frame_clk = 1'b0;
        bus.keycode = 8'h00;
        bus.tank0_X = 10'd100;   bus.tank0_Y = 10'd100;
        bus.tank1_X = 10'd290;   bus.tank1_Y = 10'd230;
        bus.bullet0_X = 10'd300; bus.bullet0_Y = 10'd240;
        bus.bullet1_X = 10'd110; bus.bullet1_Y = 10'd110;
        bus.hit0 = 2'b00;
        bus.hit1 = 2'b00;

        repeat (3) @(negedge Clk);
        chk("rst_state", bus.game_state, 2'b00);
        chk("rst_freeze", bus.freeze, 1'b1);
        chk("rst_rr", bus.round_reset, 1'b0);
        chk("rst_score0", bus.score0, 4'd0);
        chk("rst_score1", bus.score1, 4'd0);
        chk("rst_winner", bus.winner, 2'b00);
        Reset = 1'b0;

        do_frame();
        chk("idle_nokey", bus.game_state, 2'b00);

        bus.keycode = 8'h13;
        rr0 = rr_cnt;
        do_frame();
        chk("start_rr", rr_cnt - rr0, 1);
        chk("start_state", bus.game_state, 2'b01);
        chk("start_freeze", bus.freeze, 1'b0);
        chk("start_score0", bus.score0, 4'd0);
        chk("start_score1", bus.score1, 4'd0);

        // Near misses and a non-01 hit code, with start key still held.
        rr0 = rr_cnt;
        bus.hit0 = 2'b01;
        bus.bullet0_X = 10'd330;
        do_frame();
        chk("miss_330", bus.game_state, 2'b01);
        bus.bullet0_X = 10'd281;
        do_frame();
        chk("miss_281", bus.game_state, 2'b01);
        bus.bullet0_X = 10'd300;
        bus.hit0 = 2'b11;
        do_frame();
        chk("miss_code11", bus.game_state, 2'b01);
        chk("miss_score0", bus.score0, 4'd0);
        chk("play_key_ignored_rr", rr_cnt - rr0, 0);

        // First scoring round; hit held through PAUSE must be ignored.
        rr0 = rr_cnt;
        bus.hit0 = 2'b01;
        do_frame();
        chk("hit_score0", bus.score0, 4'd1);
        chk("hit_state", bus.game_state, 2'b10);
        chk("hit_freeze", bus.freeze, 1'b1);
        repeat (60) do_frame();
        chk("pause60_state", bus.game_state, 2'b10);
        chk("pause60_score0", bus.score0, 4'd1);
        chk("pause60_rr", rr_cnt - rr0, 0);
        bus.hit0 = 2'b00;
        do_frame();
        chk("resume_rr", rr_cnt - rr0, 1);
        chk("resume_state", bus.game_state, 2'b01);
        chk("resume_freeze", bus.freeze, 1'b0);

        bus.bullet0_X = 10'd282;
        round(1'b1, 1'b0, "edge_left");
        chk("edge_left_score0", bus.score0, 4'd2);
        bus.bullet0_X = 10'd322;
        round(1'b1, 1'b0, "edge_right");
        chk("edge_right_score0", bus.score0, 4'd3);
        bus.bullet0_X = 10'd300;

        // Reset with the pause counter at 30.
        bus.hit1 = 2'b01;
        do_frame();
        bus.hit1 = 2'b00;
        chk("prst_score1", bus.score1, 4'd1);
        repeat (30) do_frame();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("prst_state", bus.game_state, 2'b00);
        chk("prst_score0", bus.score0, 4'd0);
        chk("prst_score1", bus.score1, 4'd0);
        chk("prst_rr", bus.round_reset, 1'b0);
        chk("prst_freeze", bus.freeze, 1'b1);
        Reset = 1'b0;

        do_frame();
        chk("restart_state", bus.game_state, 2'b01);
        for (int i = 1; i <= 4; i++) begin
            round(1'b0, 1'b1, "p1");
            chk("p1_score1", bus.score1, i);
            chk("p1_state", bus.game_state, 2'b01);
        end
        rr0 = rr_cnt;
        round(1'b0, 1'b1, "p1win");
        chk("p1win_score1", bus.score1, 4'd5);
        chk("p1win_state", bus.game_state, 2'b11);
        chk("p1win_winner", bus.winner, 2'b10);
        chk("p1win_rr", rr_cnt - rr0, 0);

        bus.keycode = 8'h00;
        do_frame();
        chk("over_nokey", bus.game_state, 2'b11);
        bus.keycode = 8'h13;
        do_frame();
        chk("over_to_idle", bus.game_state, 2'b00);
        chk("over_score1_kept", bus.score1, 4'd5);
        rr0 = rr_cnt;
        do_frame();
        chk("new_game_state", bus.game_state, 2'b01);
        chk("new_game_score1", bus.score1, 4'd0);
        chk("new_game_winner", bus.winner, 2'b00);
        chk("new_game_rr", rr_cnt - rr0, 1);

        repeat (4) round(1'b1, 1'b0, "p0");
        repeat (4) round(1'b0, 1'b1, "p1b");
        chk("pre_tie_score0", bus.score0, 4'd4);
        chk("pre_tie_score1", bus.score1, 4'd4);
        rr0 = rr_cnt;
        round(1'b1, 1'b1, "tie");
`ifdef GAME_TIE_ROUND_EN
        chk("tie_score0", bus.score0, 4'd4);
        chk("tie_score1", bus.score1, 4'd4);
        chk("tie_state", bus.game_state, 2'b01);
        chk("tie_rr", rr_cnt - rr0, 1);
        chk("tie_winner", bus.winner, 2'b00);
`else
        chk("tie_score0", bus.score0, 4'd5);
        chk("tie_score1", bus.score1, 4'd5);
        chk("tie_state", bus.game_state, 2'b11);
        chk("tie_rr", rr_cnt - rr0, 0);
        chk("tie_winner", bus.winner, 2'b11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
